// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - load sequencer that clears ctrl_unit, streams a program into it and starts it
module prog_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          autorun,
  input  logic          go,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          ctrl_rst,
  output logic          load,
  output logic [7:0]    instr_i,
  output logic          state,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          prog_valid,
  output logic [AW:0]   wr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_RUN    = 3'd4
  } fsm_t;

  localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);

  fsm_t        cur, nxt;
  logic [AW:0] len_q;
  logic        autorun_q;

  logic        len_ok, start_ok, can_start, xfer, last_word;

  logic        in_ready_d, ctrl_rst_d, load_d, state_d, busy_d, done_d, err_d, prog_valid_d;
  logic [7:0]  instr_d;
  logic [AW:0] wr_cnt_d;

  assign len_ok    = (len != '0) && (len <= MAX_LEN);
  assign can_start = (cur == S_IDLE) || (cur == S_RUN);
  assign start_ok  = can_start && start && len_ok;
  // in_ready is registered, so a transfer never depends combinationally on in_valid downstream
  assign xfer      = (cur == S_LOAD) && in_valid && in_ready;
  assign last_word = xfer && ((wr_cnt + 1'b1) == len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= S_IDLE;
      len_q      <= '0;
      autorun_q  <= 1'b0;
      in_ready   <= 1'b0;
      ctrl_rst   <= 1'b0;
      load       <= 1'b0;
      instr_i    <= 8'h00;
      state      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      prog_valid <= 1'b0;
      wr_cnt     <= '0;
    end else begin
      cur        <= nxt;
      in_ready   <= in_ready_d;
      ctrl_rst   <= ctrl_rst_d;
      load       <= load_d;
      instr_i    <= instr_d;
      state      <= state_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      prog_valid <= prog_valid_d;
      wr_cnt     <= wr_cnt_d;
      if (start_ok && !abort) begin
        len_q     <= len;
        autorun_q <= autorun;
      end
    end
  end

  always_comb begin
    nxt = cur;
    if (abort) begin
      nxt = S_IDLE;
    end else begin
      case (cur)
        S_IDLE: begin
          // start outranks go even when its len is rejected
          if (start) begin
            if (len_ok) nxt = S_CLEAR;
          end else if (go && prog_valid) begin
            nxt = S_RUN;
          end
        end
        S_CLEAR:  nxt = S_LOAD;
        S_LOAD:   if (last_word) nxt = S_SETTLE;
        S_SETTLE: nxt = autorun_q ? S_RUN : S_IDLE;
        S_RUN:    if (start && len_ok) nxt = S_CLEAR;
        default:  nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl_rst_d   = (nxt == S_CLEAR);
    in_ready_d   = (nxt == S_LOAD);
    state_d      = (nxt == S_RUN);
    busy_d       = (nxt == S_CLEAR) || (nxt == S_LOAD) || (nxt == S_SETTLE);
    done_d       = (nxt == S_SETTLE);
    load_d       = xfer && !abort;
    instr_d      = (xfer && !abort) ? in_data : instr_i;
    err_d        = !abort && can_start && start && !len_ok;

    prog_valid_d = prog_valid;
    if (abort) begin
      if (cur == S_CLEAR || cur == S_LOAD || cur == S_SETTLE) prog_valid_d = 1'b0;
    end else if (start_ok) begin
      prog_valid_d = 1'b0;
    end else if (nxt == S_SETTLE) begin
      prog_valid_d = 1'b1;
    end

    wr_cnt_d = wr_cnt;
    if (!abort) begin
      if (start_ok) begin
        wr_cnt_d = '0;
      end else if (xfer && (wr_cnt != len_q)) begin
        wr_cnt_d = wr_cnt + 1'b1;
      end
    end
  end

endmodule
